// File: rtl/fpu_cvt_pkg.sv
// Shared definitions for the FPU format converters: rounding modes, flag layout,
// recoded-float constants and the rounding-increment rule.
package fpu_cvt_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN,
    CLS_FIN
  } cls_e;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [32:0] F32_CANON_NAN = 33'h0_E040_0000;
  localparam logic [8:0]  F32_EXP_INF   = 9'h180;
  localparam logic [8:0]  F32_EXP_MAX   = 9'h17F;
  localparam logic [22:0] F32_FRAC_MAX  = 23'h7F_FFFF;
  localparam logic [11:0] F64_BIAS      = 12'h800;
  localparam logic [8:0]  F32_BIAS      = 9'h100;

  function automatic rm_e rm_decode(input logic [2:0] raw);
    case (raw)
      3'd1:    return RM_RTZ;
      3'd2:    return RM_RDN;
      3'd3:    return RM_RUP;
      3'd4:    return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

  function automatic logic round_inc(input rm_e rm, input logic sign, input logic guard,
                                     input logic sticky, input logic lsb);
    case (rm)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign & (guard | sticky);
      RM_RUP:  return ~sign & (guard | sticky);
      RM_RMM:  return guard;
      default: return guard & (sticky | lsb);
    endcase
  endfunction

endpackage

// File: rtl/recfn_f64_to_f32_pipe_if.sv
// Request/response channel of the f64->f32 recoded narrowing converter.
interface recfn_f64_to_f32_pipe_if;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [64:0] io_in_bits_in;
  logic [2:0]  io_in_bits_rm;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [32:0] io_out_bits_out;
  logic [4:0]  io_out_bits_exc;

  modport master (
    output io_in_valid, io_in_bits_in, io_in_bits_rm, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_out, io_out_bits_exc
  );

  modport slave (
    input  io_in_valid, io_in_bits_in, io_in_bits_rm, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_out, io_out_bits_exc
  );
endinterface

// File: rtl/recfn_round_pack_f32.sv
// Rounds a pre-aligned significand to recoded f32 and raises the RISC-V flags.
module recfn_round_pack_f32
  import fpu_cvt_pkg::*;
(
  input  cls_e               i_cls,
  input  logic               i_sign,
  input  logic signed [12:0] i_e,
  input  logic [23:0]        i_kept,
  input  logic [4:0]         i_p,
  input  logic               i_guard,
  input  logic               i_sticky,
  input  rm_e                i_rm,
  input  logic               i_tiny,
  output logic [32:0]        o_out,
  output logic [4:0]         o_exc
);

  logic [24:0]        w_kept25;
  logic               w_inc;
  logic [24:0]        w_sum;
  logic               w_carry;
  logic [23:0]        w_sig;
  logic signed [12:0] w_er;
  logic               w_ovf;
  logic               w_ovf_inf;
  logic               w_nx;
  logic [8:0]         w_exp;

  // i_p is the bit position of the result lsb inside the 24-bit frame (24 = nothing kept)
  assign w_kept25  = {1'b0, i_kept};
  assign w_inc     = round_inc(i_rm, i_sign, i_guard, i_sticky, w_kept25[i_p]);
  assign w_sum     = w_kept25 + (w_inc ? (25'd1 << i_p) : 25'd0);
  assign w_carry   = w_sum[24];
  assign w_sig     = w_carry ? w_sum[24:1] : w_sum[23:0];
  assign w_er      = i_e + $signed({12'd0, w_carry});
  assign w_ovf     = w_er > 13'sd127;
  assign w_ovf_inf = (i_rm == RM_RNE) | (i_rm == RM_RMM) |
                     ((i_rm == RM_RUP) & ~i_sign) | ((i_rm == RM_RDN) & i_sign);
  assign w_nx      = i_guard | i_sticky | w_ovf;
  assign w_exp     = w_er[8:0] + F32_BIAS;

  always_comb begin
    o_out = '0;
    o_exc = '0;
    case (i_cls)
      CLS_ZERO: o_out = {i_sign, 32'h0};
      CLS_INF:  o_out = {i_sign, F32_EXP_INF, 23'h0};
      CLS_QNAN: o_out = F32_CANON_NAN;
      CLS_SNAN: begin
        o_out         = F32_CANON_NAN;
        o_exc[FLG_NV] = 1'b1;
      end
      CLS_FIN: begin
        if (w_ovf) begin
          o_exc[FLG_OF] = 1'b1;
          o_exc[FLG_NX] = 1'b1;
          o_out = w_ovf_inf ? {i_sign, F32_EXP_INF, 23'h0}
                            : {i_sign, F32_EXP_MAX, F32_FRAC_MAX};
        end else begin
          o_exc[FLG_NX] = w_nx;
          o_exc[FLG_UF] = i_tiny & w_nx;
          o_out = w_sig[23] ? {i_sign, w_exp, w_sig[22:0]} : {i_sign, 32'h0};
        end
      end
      default: o_out = '0;
    endcase
  end

endmodule

// File: rtl/recfn_f64_to_f32_pipe.sv
// Two-stage recoded f64 -> recoded f32 narrowing converter with valid/ready and flush.
module recfn_f64_to_f32_pipe
  import fpu_cvt_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_kill,
  recfn_f64_to_f32_pipe_if.slave  io
);

  logic w_adv, w_ld_p1, w_acc;

  logic               w_sign_p0;
  logic [11:0]        w_exp_p0;
  logic [52:0]        w_sig_p0;
  logic signed [12:0] w_e_raw_p0;
  cls_e               w_cls_p0;
  rm_e                w_rm_p0;
  logic signed [12:0] w_e_p0;
  logic [23:0]        w_kept_p0;
  logic [4:0]         w_p_p0;
  logic [5:0]         w_sh_p0;
  logic               w_g_p0, w_s_p0;
  logic               w_carry_unb_p0, w_tiny_p0;

  logic               r_vld_p1, r_vld_p2;
  cls_e               r_cls_p1;
  logic               r_sign_p1;
  logic signed [12:0] r_e_p1;
  logic [23:0]        r_kept_p1;
  logic [4:0]         r_p_p1;
  logic               r_g_p1, r_s_p1, r_tiny_p1;
  rm_e                r_rm_p1;
  logic [32:0]        w_out_p1, r_out_p2;
  logic [4:0]         w_exc_p1, r_exc_p2;

  assign w_adv   = ~r_vld_p2 | io.io_out_ready;
  assign w_ld_p1 = ~r_vld_p1 | w_adv;
  assign w_acc   = io.io_in_valid & w_ld_p1;

  assign io.io_in_ready     = w_ld_p1;
  assign io.io_out_valid    = r_vld_p2;
  assign io.io_out_bits_out = r_out_p2;
  assign io.io_out_bits_exc = r_exc_p2;

  // ---- stage 0: classify and align to the target precision
  assign w_sign_p0  = io.io_in_bits_in[64];
  assign w_exp_p0   = io.io_in_bits_in[63:52];
  assign w_sig_p0   = {1'b1, io.io_in_bits_in[51:0]};
  assign w_e_raw_p0 = $signed({1'b0, w_exp_p0}) - $signed({1'b0, F64_BIAS});
  assign w_rm_p0    = rm_decode(io.io_in_bits_rm);

  // Tininess is judged on the 24-bit rounding with unbounded exponent; only E=-127 can escape it.
  assign w_carry_unb_p0 = (&w_sig_p0[52:29]) &
                          round_inc(w_rm_p0, w_sign_p0, w_sig_p0[28], |w_sig_p0[27:0], 1'b1);
  assign w_tiny_p0 = (w_e_raw_p0 < -13'sd127) | ((w_e_raw_p0 == -13'sd127) & ~w_carry_unb_p0);

  always_comb begin
    case (w_exp_p0[11:9])
      3'b000:  w_cls_p0 = CLS_ZERO;
      3'b110:  w_cls_p0 = CLS_INF;
      3'b111:  w_cls_p0 = w_sig_p0[51] ? CLS_QNAN : CLS_SNAN;
      default: w_cls_p0 = CLS_FIN;
    endcase
    w_e_p0    = w_e_raw_p0;
    w_kept_p0 = w_sig_p0[52:29];
    w_p_p0    = 5'd0;
    w_sh_p0   = 6'd28;
    w_g_p0    = w_sig_p0[28];
    w_s_p0    = |w_sig_p0[27:0];
    if (w_e_raw_p0 < -13'sd150) begin
      // Far below the smallest subnormal: rounds like a pure sticky at E=-150.
      w_e_p0    = -13'sd150;
      w_kept_p0 = 24'd0;
      w_p_p0    = 5'd24;
      w_g_p0    = 1'b0;
      w_s_p0    = 1'b1;
    end else if (w_e_raw_p0 < -13'sd126) begin
      // p = -126 - E, computed modulo 32 (-126 == 2 mod 32).
      w_p_p0    = 5'd2 - w_e_raw_p0[4:0];
      w_sh_p0   = 6'd28 + {1'b0, w_p_p0};
      w_kept_p0 = w_sig_p0[52:29] & ~((24'd1 << w_p_p0) - 24'd1);
      w_g_p0    = w_sig_p0[w_sh_p0];
      w_s_p0    = |(w_sig_p0 & ((53'd1 << w_sh_p0) - 53'd1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (io_kill) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_ld_p1) r_vld_p1 <= w_acc;
      if (w_adv)   r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- stage 1: aligned operand register
  always_ff @(posedge clock) begin
    if (w_acc) begin
      r_cls_p1  <= w_cls_p0;
      r_sign_p1 <= w_sign_p0;
      r_e_p1    <= w_e_p0;
      r_kept_p1 <= w_kept_p0;
      r_p_p1    <= w_p_p0;
      r_g_p1    <= w_g_p0;
      r_s_p1    <= w_s_p0;
      r_rm_p1   <= w_rm_p0;
      r_tiny_p1 <= w_tiny_p0;
    end
  end

  recfn_round_pack_f32 u_round (
    .i_cls    (r_cls_p1),
    .i_sign   (r_sign_p1),
    .i_e      (r_e_p1),
    .i_kept   (r_kept_p1),
    .i_p      (r_p_p1),
    .i_guard  (r_g_p1),
    .i_sticky (r_s_p1),
    .i_rm     (r_rm_p1),
    .i_tiny   (r_tiny_p1),
    .o_out    (w_out_p1),
    .o_exc    (w_exc_p1)
  );

  // ---- stage 2: rounded, packed result register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_p2 <= '0;
      r_exc_p2 <= '0;
    end else if (w_adv & r_vld_p1) begin
      r_out_p2 <= w_out_p1;
      r_exc_p2 <= w_exc_p1;
    end
  end

endmodule

// File: doc/recfn_f64_to_f32_pipe.md
# recfn_f64_to_f32_pipe

- Two-stage pipelined narrowing converter: recoded double (65-bit HardFloat recFN) to recoded single (33-bit recFN).
- Performs IEEE rounding and produces RISC-V exception flags.
- Counterpart of the single-to-double widening path; used by the FPU's FCVT.S.D and store-narrowing paths.
- Streams one conversion per cycle behind a valid/ready handshake with a flush input.

## Interface
No parameters.
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all valid bits and output registers
- io_kill  in  1  flush: drops every in-flight and same-cycle-accepted operation
- io_in_valid  in  1  request valid
- io_in_ready  out  1  converter can accept this cycle
- io_in_bits_in  in  65  recoded f64: sign[64], exp[63:52], frac[51:0]
- io_in_bits_rm  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes treated as RNE
- io_out_valid  out  1  result valid
- io_out_ready  in  1  consumer accepts
- io_out_bits_out  out  33  recoded f32: sign[32], exp[31:23], frac[22:0]
- io_out_bits_exc  out  5  {NV, DZ, OF, UF, NX}; DZ always 0

## Operation
- Input classification uses exp[63:61]:
  - 000: zero.
  - 110: infinity.
  - 111: NaN; signalling when frac[51]=0.
  - Anything else: finite, with E = exp - 0x800 as 13-bit signed and significand 1.frac.
- Zero: output {sign, 32'h0}, flags 0.
- Infinity: output {sign, 32'hC000_0000}, flags 0.
- NaN: output canonical 33'h0_E040_0000. NV=1 only for signalling NaN.
- Finite, E ≥ -126 (normal target): keep 24 significand bits; guard = frac[28], sticky = OR(frac[27:0]).
- Finite, -150 ≤ E ≤ -127 (subnormal target): keep E+150 significand bits; the rest feed guard/sticky. The exponent stays E, and the frac bits below kept precision are zero.
- Finite, E < -150: magnitude below half of 2^-149.
  - Result is zero, or 2^-149 (exp 0x6B, frac 0) when the mode rounds away from zero.
  - Guard = 0, sticky = 1.
- Rounding increment by mode:
  - RNE: guard & (sticky | lsb).
  - RMM: guard.
  - RTZ: 0.
  - RDN: sign & (guard|sticky).
  - RUP: ~sign & (guard|sticky).
- A significand carry-out sets E+1. Output exp = E + 0x100 (9 bits).
- Overflow: rounded E > 127 sets OF and NX.
  - Result is ±inf (exp 0x180) for RNE, RMM, RUP-positive and RDN-negative.
  - Otherwise result is ±max finite (exp 0x17F, frac 7F_FFFF).
- NX = guard|sticky, or overflow.
- UF = tiny & NX. Tininess is detected after rounding: the result, rounded to 24 bits with unbounded exponent, has E < -126.

## Timing
- Stage 1 registers classification, E, kept significand, guard, sticky, rm and sign.
- Stage 2 registers the rounded, packed result and flags.
- Latency is 2 cycles from the accept edge to io_out_valid.
- Throughput is 1 per cycle.
- Accept = io_in_valid & io_in_ready. Output transfer = io_out_valid & io_out_ready.
- s2 advances when !s2_valid | io_out_ready. s1 advances when s2 advances. io_in_ready = !s1_valid | s1 advances (combinational from io_out_ready).
- When stalled, stage registers hold their values. io_out_bits is stable while io_out_valid & !io_out_ready.
- io_kill: on the next edge s1_valid = s2_valid = 0. An operation accepted in the same cycle is discarded. Data registers may keep stale values.
- Reset values: s1_valid = s2_valid = 0, io_out_valid = 0, io_out_bits_out = 0, io_out_bits_exc = 0. io_in_ready = 1 in the first cycle after reset.
- Reset asserted mid-operation loses in-flight results with no output pulse.

## Structure
- Shared package (fpu_cvt_pkg) holds:
  - rounding-mode enum;
  - flag bit indices;
  - recoded-f32 constants (canonical NaN, infinity exponent, max finite);
  - the f64/f32 recoded bias constants 0x800 and 0x100.
- One combinational sub-module, recfn_round_pack_f32, holds the stage-2 logic: increment decision, carry, overflow/underflow, packing.
- The top level holds the two pipeline registers, handshake and kill.

## Test plan
- 1.0 (65'h0_8000_0000_0000_0000), RNE → 33'h0_8000_0000, exc 0, out_valid exactly 2 cycles after accept.
- 1+2^-24 (65'h0_8000_0000_1000_0000):
  - RNE → 33'h0_8000_0000, exc 5'b00001.
  - RUP → 33'h0_8000_0001, exc 5'b00001.
- 2^128 (65'h0_8800_0000_0000_0000):
  - RNE → 33'h0_C000_0000, exc 5'b00101.
  - RTZ → 33'h0_BFFF_FFFF, exc 5'b00101.
- sNaN 65'h0_E000_0000_0000_0001 → 33'h0_E040_0000, exc 5'b10000.
- -0 (65'h1_0000_0000_0000_0000) → 33'h1_0000_0000, exc 0.
- Handshake:
  - 3 back-to-back inputs with io_out_ready low for 5 cycles → io_in_ready drops after 2 accepts; all 3 results emerge in order with no loss.
  - io_kill with 2 ops in flight → no io_out_valid for them.
